rgb_line_buffer: RTL and testbench

RGB_LINE_BUFFER -- requirements
Module: rgb_line_buffer

---
 rtl/rgb_line_buffer.sv | 182 ++++++++++++++++++
 tb/tb_rgb_line_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rgb_line_buffer.sv
// Two-bank RGB line buffer between a pixel stream writer and an HDMI address-driven reader.
// Read data is registered, one cycle after rd_addr. wr_ready drops while both banks hold unread lines.
module rgb_line_buffer #(
  parameter int H_PIXEL = 640,
  parameter int ADDR_W  = 21
) (
  input  logic              clk_low,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [23:0]       wr_data,
  input  logic              wr_sof,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              underflow
);

  localparam int COL_W = (H_PIXEL > 1) ? $clog2(H_PIXEL) : 1;

  typedef enum logic [1:0] {
    WAIT_SOF  = 2'd0,
    FILL      = 2'd1,
    WAIT_FREE = 2'd2
  } wr_state_e;

  wr_state_e         state_q, state_d;
  logic              wb_q, wb_d;
  logic [COL_W-1:0]  wr_col_q, wr_col_d;
  logic [1:0]        full_q, full_d;
  logic              rb_q, rb_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [23:0]       pix_q, pix_d;
  logic              underflow_q, underflow_d;

  logic [23:0]       bank0_mem [H_PIXEL];
  logic [23:0]       bank1_mem [H_PIXEL];

  logic              accept;
  logic              resync;
  logic              wr_en;
  logic              wr_bank;
  logic [COL_W-1:0]  wr_addr;
  logic [ADDR_W-1:0] rd_diff;
  logic              rd_wrap;
  logic              rd_adv;
  logic              rd_bank;
  logic [COL_W-1:0]  rd_col;
  logic              rd_in_range;
  logic              rd_hit;
  logic [23:0]       mem_rd;

  assign mem_rd = rd_bank ? bank1_mem[rd_col] : bank0_mem[rd_col];

  always_comb begin
    state_d     = state_q;
    wb_d        = wb_q;
    wr_col_d    = wr_col_q;
    full_d      = full_q;
    rb_d        = rb_q;
    line_base_d = line_base_q;
    underflow_d = underflow_q;
    pix_d       = 24'd0;
    wr_en       = 1'b0;
    wr_bank     = wb_q;
    wr_addr     = wr_col_q;

    unique case (state_q)
      WAIT_SOF: wr_ready = 1'b1;
      FILL:     wr_ready = !full_q[wb_q];
      default:  wr_ready = 1'b0;
    endcase
    accept = wr_valid && wr_ready;
    resync = accept && wr_sof;

    // Reader: clears happen first so a same-cycle writer set on the same flag wins.
    rd_diff     = rd_addr - line_base_q;
    rd_wrap     = (rd_addr == '0) && (line_base_q != '0);
    rd_adv      = !rd_wrap && (rd_diff == ADDR_W'(H_PIXEL));
    rd_bank     = rb_q;
    rd_col      = rd_diff[COL_W-1:0];
    rd_in_range = (rd_diff < ADDR_W'(H_PIXEL));
    if (rd_wrap) begin
      full_d[rb_q] = 1'b0;
      rb_d         = 1'b0;
      line_base_d  = '0;
      rd_bank      = 1'b0;
      rd_col       = '0;
      rd_in_range  = 1'b1;
    end else if (rd_adv) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
      line_base_d  = line_base_q + ADDR_W'(H_PIXEL);
      rd_bank      = ~rb_q;
      rd_col       = '0;
      rd_in_range  = 1'b1;
    end

    // A resync invalidates every stored line, so its read cycle returns black without flagging.
    rd_hit = rd_in_range && full_q[rd_bank] && !resync;
    if (rd_hit) begin
      pix_d = mem_rd;
    end
    if (rd_in_range && !full_q[rd_bank] && !resync) begin
      underflow_d = 1'b1;
    end

    if (resync) begin
      full_d      = 2'b00;
      wb_d        = 1'b0;
      wr_col_d    = COL_W'(1);
      wr_en       = 1'b1;
      wr_bank     = 1'b0;
      wr_addr     = '0;
      underflow_d = 1'b0;
      state_d     = FILL;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            wr_en = 1'b1;
            if (wr_col_q == COL_W'(H_PIXEL - 1)) begin
              full_d[wb_q] = 1'b1;
              wb_d         = ~wb_q;
              wr_col_d     = '0;
              if (full_d[~wb_q]) begin
                state_d = WAIT_FREE;
              end
            end else begin
              wr_col_d = wr_col_q + COL_W'(1);
            end
          end
        end
        WAIT_FREE: begin
          if (!full_d[wb_q]) begin
            state_d = FILL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_low or negedge reset) begin
    if (!reset) begin
      state_q     <= WAIT_SOF;
      wb_q        <= 1'b0;
      wr_col_q    <= '0;
      full_q      <= 2'b00;
      rb_q        <= 1'b0;
      line_base_q <= '0;
      pix_q       <= 24'd0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_q        <= wb_d;
      wr_col_q    <= wr_col_d;
      full_q      <= full_d;
      rb_q        <= rb_d;
      line_base_q <= line_base_d;
      pix_q       <= pix_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk_low) begin
    if (wr_en) begin
      if (wr_bank) begin
        bank1_mem[wr_addr] <= wr_data;
      end else begin
        bank0_mem[wr_addr] <= wr_data;
      end
    end
  end

  assign red       = pix_q[23:16];
  assign green     = pix_q[15:8];
  assign blue      = pix_q[7:0];
  assign underflow = underflow_q;

endmodule

// File: tb/tb_rgb_line_buffer.sv
// Directed bench for rgb_line_buffer with a 4-pixel line.
module tb_rgb_line_buffer;

  localparam int H_PIXEL = 4;
  localparam int ADDR_W  = 21;

  logic              clk_low = 1'b0;
  logic              reset   = 1'b0;
  logic              wr_valid = 1'b0;
  logic [23:0]       wr_data  = 24'd0;
  logic              wr_sof   = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] rd_addr  = '0;
  logic [7:0]        red, green, blue;
  logic              underflow;

  int n_checks = 0;
  int n_fail   = 0;

  rgb_line_buffer #(.H_PIXEL(H_PIXEL), .ADDR_W(ADDR_W)) dut (
    .clk_low  (clk_low),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_sof   (wr_sof),
    .wr_ready (wr_ready),
    .rd_addr  (rd_addr),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .underflow(underflow)
  );

  always #5 clk_low = ~clk_low;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_low);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_low);
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
    rd_addr  = '0;
    reset    = 1'b0;
    #2;
    reset    = 1'b1;
    tick();
  endtask

  task automatic push(input logic [23:0] d, input logic sof);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_sof   = sof;
    tick();
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
  endtask

  function automatic logic [23:0] rgb();
    return {red, green, blue};
  endfunction

  // A write and an effective read must never target the same bank in one cycle.
  always @(negedge clk_low) begin
    if (reset && dut.wr_en && dut.rd_hit) begin
      check_eq("bank_collision", {31'd0, dut.wr_bank == dut.rd_bank}, 32'd0);
    end
  end

  logic [23:0] line_a [4];
  logic [23:0] two_lines [9];

  initial begin
    line_a[0] = 24'h010203;
    line_a[1] = 24'h020304;
    line_a[2] = 24'h030405;
    line_a[3] = 24'h040506;
    for (int i = 0; i < 9; i++) begin
      two_lines[i] = {8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i)};
    end

    // Reset state while reset is held
    #13;
    check_eq("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check_eq("rst_rgb", {8'd0, rgb()}, 32'd0);
    check_eq("rst_underflow", {31'd0, underflow}, 32'd0);
    check_eq("rst_full", {30'd0, dut.full_q}, 32'd0);

    // Read of an empty buffer
    do_reset();
    check_eq("empty_rgb", {8'd0, rgb()}, 32'd0);
    check_eq("empty_underflow", {31'd0, underflow}, 32'd1);

    // One line then read-back with one cycle latency
    do_reset();
    push(line_a[0], 1'b1);
    for (int i = 1; i < 4; i++) push(line_a[i], 1'b0);
    check_eq("line_full", {30'd0, dut.full_q}, 32'h1);
    check_eq("line_wb", {31'd0, dut.wb_q}, 32'd1);
    check_eq("line_wr_ready", {31'd0, wr_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd_addr = ADDR_W'(i);
      tick();
      check_eq($sformatf("line_rd%0d", i), {8'd0, rgb()}, {8'd0, line_a[i]});
    end

    // Two lines fill both banks; reading past line 0 frees bank 0
    do_reset();
    push(two_lines[0], 1'b1);
    for (int i = 1; i < 8; i++) push(two_lines[i], 1'b0);
    wr_valid = 1'b1;
    wr_data  = two_lines[8];
    #1;
    check_eq("two_full", {30'd0, dut.full_q}, 32'h3);
    check_eq("two_ready_9th", {31'd0, wr_ready}, 32'd0);
    wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_addr = ADDR_W'(i);
      tick();
      check_eq($sformatf("two_rd%0d", i), {8'd0, rgb()}, {8'd0, two_lines[i]});
    end
    check_eq("two_ready_hold", {31'd0, wr_ready}, 32'd0);
    rd_addr = ADDR_W'(4);
    tick();
    check_eq("two_rd4", {8'd0, rgb()}, {8'd0, two_lines[4]});
    check_eq("two_ready_free", {31'd0, wr_ready}, 32'd1);
    check_eq("two_full_after", {30'd0, dut.full_q}, 32'h2);
    check_eq("two_rb", {31'd0, dut.rb_q}, 32'd1);

    // SOF in the middle of a line resynchronises the writer
    do_reset();
    push(line_a[0], 1'b1);
    for (int i = 1; i < 4; i++) push(line_a[i], 1'b0);
    push(24'h111111, 1'b0);
    push(24'h222222, 1'b0);
    check_eq("sof_pre_underflow", {31'd0, underflow}, 32'd1);
    check_eq("sof_pre_col", {30'd0, dut.wr_col_q}, 32'd2);
    push(24'hAABBCC, 1'b1);
    check_eq("sof_full", {30'd0, dut.full_q}, 32'd0);
    check_eq("sof_underflow", {31'd0, underflow}, 32'd0);
    check_eq("sof_wb", {31'd0, dut.wb_q}, 32'd0);
    check_eq("sof_col", {30'd0, dut.wr_col_q}, 32'd1);
    push(24'h112233, 1'b0);
    push(24'h445566, 1'b0);
    push(24'h778899, 1'b0);
    rd_addr = '0;
    tick();
    check_eq("sof_rd0", {8'd0, rgb()}, 32'h00AABBCC);
    rd_addr = ADDR_W'(1);
    tick();
    check_eq("sof_rd1", {8'd0, rgb()}, 32'h00112233);

    // Reader advances in the same cycle the writer completes bank 0
    do_reset();
    push(line_a[0], 1'b1);
    push(line_a[1], 1'b0);
    push(line_a[2], 1'b0);
    rd_addr = ADDR_W'(4);
    push(line_a[3], 1'b0);
    check_eq("race_full", {30'd0, dut.full_q}, 32'h1);
    check_eq("race_rb", {31'd0, dut.rb_q}, 32'd1);
    check_eq("race_base", {11'd0, dut.line_base_q}, 32'd4);
    check_eq("race_ready", {31'd0, wr_ready}, 32'd1);

    // Asynchronous reset pulse between edges in the middle of a line
    do_reset();
    push(line_a[0], 1'b1);
    for (int i = 1; i < 4; i++) push(line_a[i], 1'b0);
    rd_addr = ADDR_W'(1);
    push(24'h333333, 1'b0);
    check_eq("arst_pre_rgb", {8'd0, rgb()}, {8'd0, line_a[1]});
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_rgb", {8'd0, rgb()}, 32'd0);
    check_eq("arst_underflow", {31'd0, underflow}, 32'd0);
    check_eq("arst_ready", {31'd0, wr_ready}, 32'd1);
    check_eq("arst_full", {30'd0, dut.full_q}, 32'd0);
    reset   = 1'b1;
    rd_addr = '0;
    for (int i = 0; i < 4; i++) push(two_lines[i], 1'b0);
    check_eq("arst_drop_full", {30'd0, dut.full_q}, 32'd0);
    check_eq("arst_drop_rgb", {8'd0, rgb()}, 32'd0);
    check_eq("arst_drop_underflow", {31'd0, underflow}, 32'd1);
    push(two_lines[4], 1'b1);
    for (int i = 5; i < 8; i++) push(two_lines[i], 1'b0);
    rd_addr = ADDR_W'(2);
    tick();
    check_eq("arst_resume_rd2", {8'd0, rgb()}, {8'd0, two_lines[6]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
